// File: rtl/elevator_pkg.sv
// Shared types for the elevator controller: cabin state encoding and the
// active-low 7-segment digit patterns (bit 0 = segment a .. bit 6 = segment g).
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } elev_state_e;

    localparam logic [6:0] SEG7_0     = 7'b1000000;
    localparam logic [6:0] SEG7_1     = 7'b1111001;
    localparam logic [6:0] SEG7_2     = 7'b0100100;
    localparam logic [6:0] SEG7_3     = 7'b0110000;
    localparam logic [6:0] SEG7_4     = 7'b0011001;
    localparam logic [6:0] SEG7_5     = 7'b0010010;
    localparam logic [6:0] SEG7_6     = 7'b0000010;
    localparam logic [6:0] SEG7_7     = 7'b1111000;
    localparam logic [6:0] SEG7_8     = 7'b0000000;
    localparam logic [6:0] SEG7_9     = 7'b0010000;
    localparam logic [6:0] SEG7_BLANK = 7'b1111111;

endpackage

// File: rtl/elevator_ctrl_if.sv
// Request-panel / status bundle between the elevator controller (slave) and
// the panel, motor and display side (master).
interface elevator_ctrl_if #(
    parameter int NUM_FLOORS = 5
);
    localparam int FLOOR_W = $clog2(NUM_FLOORS);

    logic                  rqstValid;
    logic [FLOOR_W-1:0]    rqstFloor;
    logic                  doorBlocked;
    logic [FLOOR_W-1:0]    currentFloor;
    logic                  movingUp;
    logic                  movingDown;
    logic                  doorOpen;
    logic [NUM_FLOORS-1:0] pending;
    logic [6:0]            seg;

    modport master (
        output rqstValid, rqstFloor, doorBlocked,
        input  currentFloor, movingUp, movingDown, doorOpen, pending, seg
    );

    modport slave (
        input  rqstValid, rqstFloor, doorBlocked,
        output currentFloor, movingUp, movingDown, doorOpen, pending, seg
    );

endinterface

// File: rtl/seg7_decoder.sv
// Purely combinational BCD digit to active-low 7-segment decoder; codes
// above 9 blank the display.
module seg7_decoder
    import elevator_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG7_BLANK;
        case (digit_i)
            4'd0:    seg_o = SEG7_0;
            4'd1:    seg_o = SEG7_1;
            4'd2:    seg_o = SEG7_2;
            4'd3:    seg_o = SEG7_3;
            4'd4:    seg_o = SEG7_4;
            4'd5:    seg_o = SEG7_5;
            4'd6:    seg_o = SEG7_6;
            4'd7:    seg_o = SEG7_7;
            4'd8:    seg_o = SEG7_8;
            4'd9:    seg_o = SEG7_9;
            default: seg_o = SEG7_BLANK;
        endcase
    end

endmodule

// File: rtl/elevator_ctrl.sv
// N-floor SCAN elevator controller: latches requests, sweeps one floor per
// TRAVEL_CYCLES, holds the door DOOR_CYCLES per stop. Optional macro DOOR_SENSOR_EN.
module elevator_ctrl
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS    = 5,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 8
) (
    input  logic            clk,
    input  logic            rst,
    elevator_ctrl_if.slave  bus
);

    localparam int FLOOR_W = $clog2(NUM_FLOORS);
    localparam int TCW     = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DCW     = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [FLOOR_W:0]   NF_EXT    = (FLOOR_W + 1)'(NUM_FLOORS);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

    elev_state_e           state_q;
    logic [FLOOR_W-1:0]    floor_q;
    logic [NUM_FLOORS-1:0] pending_q;
    logic                  dir_up_q;
    logic [TCW-1:0]        travel_cnt_q;
    logic [DCW-1:0]        door_cnt_q;

    function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] m;
        for (int i = 0; i < NUM_FLOORS; i++) m[i] = (i > int'(f));
        return m;
    endfunction

    function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] m;
        for (int i = 0; i < NUM_FLOORS; i++) m[i] = (i < int'(f));
        return m;
    endfunction

    logic                  req_ok, req_here, door_hold, door_restart;
    logic                  go_up, go_down, step_due, stop_here;
    logic [NUM_FLOORS-1:0] req_vec, arrive_vec, clear_vec, pending_d;
    logic [FLOOR_W-1:0]    floor_step_d;

`ifdef DOOR_SENSOR_EN
    assign door_hold = bus.doorBlocked;
`else
    logic door_blocked_unused;
    assign door_blocked_unused = bus.doorBlocked;
    assign door_hold = 1'b0;
`endif

    always_comb begin
        req_ok       = bus.rqstValid && ({1'b0, bus.rqstFloor} < NF_EXT);
        req_vec      = req_ok ? (NUM_FLOORS'(1) << bus.rqstFloor) : '0;
        // A request for the floor the cabin is parked at opens/extends the door instead of latching.
        req_here     = req_ok && (bus.rqstFloor == floor_q) &&
                       (state_q == IDLE || state_q == DOOR_OPEN);
        door_restart = req_here || door_hold;
        go_up        = |(pending_q & above_mask(floor_q)) &&
                       (dir_up_q || !(|(pending_q & below_mask(floor_q))));
        go_down      = |(pending_q & below_mask(floor_q)) && !go_up;
        floor_step_d = (state_q == MOVE_UP) ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
        step_due     = (travel_cnt_q == TCW'(TRAVEL_CYCLES - 1));
        arrive_vec   = NUM_FLOORS'(1) << floor_step_d;
        stop_here    = |(arrive_vec & (pending_q | req_vec));
        clear_vec    = '0;
        if ((state_q == MOVE_UP || state_q == MOVE_DOWN) && step_due && stop_here)
            clear_vec = arrive_vec;
        // Clearing wins over a same-cycle request: the stop serves it.
        pending_d    = (pending_q | (req_here ? '0 : req_vec)) & ~clear_vec;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            floor_q      <= '0;
            pending_q    <= '0;
            dir_up_q     <= 1'b1;
            travel_cnt_q <= '0;
            door_cnt_q   <= '0;
        end else begin
            pending_q <= pending_d;
            case (state_q)
                IDLE: begin
                    if (req_here) begin
                        state_q    <= DOOR_OPEN;
                        door_cnt_q <= '0;
                    end else if (go_up || go_down) begin
                        state_q      <= go_up ? MOVE_UP : MOVE_DOWN;
                        dir_up_q     <= go_up;
                        travel_cnt_q <= '0;
                    end
                end
                MOVE_UP, MOVE_DOWN: begin
                    if ((state_q == MOVE_UP && floor_q == TOP_FLOOR) ||
                        (state_q == MOVE_DOWN && floor_q == '0)) begin
                        state_q <= IDLE;
                    end else if (step_due) begin
                        floor_q      <= floor_step_d;
                        travel_cnt_q <= '0;
                        if (stop_here) begin
                            state_q    <= DOOR_OPEN;
                            door_cnt_q <= '0;
                        end
                    end else begin
                        travel_cnt_q <= travel_cnt_q + TCW'(1);
                    end
                end
                DOOR_OPEN: begin
                    if (door_restart) begin
                        door_cnt_q <= '0;
                    end else if (door_cnt_q == DCW'(DOOR_CYCLES - 1)) begin
                        door_cnt_q   <= '0;
                        travel_cnt_q <= '0;
                        if (go_up || go_down) begin
                            state_q  <= go_up ? MOVE_UP : MOVE_DOWN;
                            dir_up_q <= go_up;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        door_cnt_q <= door_cnt_q + DCW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.currentFloor = floor_q;
    assign bus.movingUp     = (state_q == MOVE_UP);
    assign bus.movingDown   = (state_q == MOVE_DOWN);
    assign bus.doorOpen     = (state_q == DOOR_OPEN);
    assign bus.pending      = pending_q;

    seg7_decoder u_seg7 (
        .digit_i (4'(floor_q)),
        .seg_o   (bus.seg)
    );

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed bench for elevator_ctrl (5 floors, travel 4, door 8): per-cycle
// vector table plus hand-written sweep and reset-mid-move sequences.
module tb_elevator_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    elevator_ctrl_if #(.NUM_FLOORS(5)) bus ();

    elevator_ctrl #(
        .NUM_FLOORS    (5),
        .TRAVEL_CYCLES (4),
        .DOOR_CYCLES   (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic       v;
        logic [2:0] f;
        logic       b;
        int         n;
        int         ef;
        logic       eu;
        logic       ed;
        logic       eo;
        logic [4:0] ep;
    } vec_t;

    vec_t       tbl[$];
    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    int n_cmp = 0;
    int n_err = 0;

    function automatic void add(input logic v, input logic [2:0] f, input logic b, input int n,
                                input int ef, input logic eu, input logic ed, input logic eo,
                                input logic [4:0] ep);
        vec_t r;
        r.v = v; r.f = f; r.b = b; r.n = n; r.ef = ef;
        r.eu = eu; r.ed = ed; r.eo = eo; r.ep = ep;
        tbl.push_back(r);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int ef, input logic eu, input logic ed,
                             input logic eo, input logic [4:0] ep);
        check({tag, ".floor"},   int'(bus.currentFloor), ef);
        check({tag, ".up"},      int'(bus.movingUp),     int'(eu));
        check({tag, ".down"},    int'(bus.movingDown),   int'(ed));
        check({tag, ".door"},    int'(bus.doorOpen),     int'(eo));
        check({tag, ".pending"}, int'(bus.pending),      int'(ep));
        check({tag, ".seg"},     int'(bus.seg),          int'(seg_tab[ef]));
    endtask

    task automatic request(input logic [2:0] f);
        bus.rqstValid = 1'b1;
        bus.rqstFloor = f;
        @(negedge clk);
        bus.rqstValid = 1'b0;
        bus.rqstFloor = 3'd0;
    endtask

    int    stop_floor[$];
    int    stop_pend[$];
    int    exp_stop[3]  = '{3, 4, 0};
    int    exp_spend[3] = '{5'b10001, 5'b00001, 5'b00000};
    logic  found;
    logic  prev_door;
    string tag;

    initial begin
        bus.rqstValid   = 1'b0;
        bus.rqstFloor   = 3'd0;
        bus.doorBlocked = 1'b0;

        // Test 2: idle at 0, request 3
        add(1, 3, 0, 1, 0, 0, 0, 0, 5'b01000);
        add(0, 0, 0, 4, 0, 1, 0, 0, 5'b01000);
        add(0, 0, 0, 4, 1, 1, 0, 0, 5'b01000);
        add(0, 0, 0, 4, 2, 1, 0, 0, 5'b01000);
        add(0, 0, 0, 8, 3, 0, 0, 1, 5'b00000);
        add(0, 0, 0, 1, 3, 0, 0, 0, 5'b00000);
        // Out-of-range requests are ignored
        add(1, 5, 0, 1, 3, 0, 0, 0, 5'b00000);
        add(1, 7, 0, 2, 3, 0, 0, 0, 5'b00000);
        // Move down to 2
        add(1, 2, 0, 1, 3, 0, 0, 0, 5'b00100);
        add(0, 0, 0, 4, 3, 0, 1, 0, 5'b00100);
        add(0, 0, 0, 8, 2, 0, 0, 1, 5'b00000);
        add(0, 0, 0, 1, 2, 0, 0, 0, 5'b00000);
        // Test 4: request own floor opens door; repeat at door count 6 restarts timer
        add(1, 2, 0, 1, 2, 0, 0, 1, 5'b00000);
        add(0, 0, 0, 6, 2, 0, 0, 1, 5'b00000);
        add(1, 2, 0, 1, 2, 0, 0, 1, 5'b00000);
        add(0, 0, 0, 7, 2, 0, 0, 1, 5'b00000);
        add(0, 0, 0, 1, 2, 0, 0, 0, 5'b00000);
        // Test 6: door obstruction held for 20 cycles
        add(1, 2, 0, 1, 2, 0, 0, 1, 5'b00000);
`ifdef DOOR_SENSOR_EN
        add(0, 0, 1, 20, 2, 0, 0, 1, 5'b00000);
        add(0, 0, 0, 7, 2, 0, 0, 1, 5'b00000);
        add(0, 0, 0, 1, 2, 0, 0, 0, 5'b00000);
`else
        add(0, 0, 1, 7, 2, 0, 0, 1, 5'b00000);
        add(0, 0, 1, 13, 2, 0, 0, 0, 5'b00000);
        add(0, 0, 0, 1, 2, 0, 0, 0, 5'b00000);
`endif

        // Test 1: reset
        @(negedge clk);
        @(negedge clk);
        check_all("reset", 0, 0, 0, 0, 5'b00000);
        $display("reset: floor=%0d pending=%b seg=%b", bus.currentFloor, bus.pending, bus.seg);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                bus.rqstValid   = tbl[i].v;
                bus.rqstFloor   = tbl[i].f;
                bus.doorBlocked = tbl[i].b;
                @(negedge clk);
                tag = $sformatf("vec%0d.%0d", i, k);
                check_all(tag, tbl[i].ef, tbl[i].eu, tbl[i].ed, tbl[i].eo, tbl[i].ep);
            end
            $display("vec %0d: req=%0b/%0d blk=%0b x%0d -> floor=%0d up=%0b dn=%0b door=%0b pend=%b",
                     i, tbl[i].v, tbl[i].f, tbl[i].b, tbl[i].n, bus.currentFloor,
                     bus.movingUp, bus.movingDown, bus.doorOpen, bus.pending);
        end
        bus.rqstValid   = 1'b0;
        bus.doorBlocked = 1'b0;

        // Test 3: SCAN sweep, stops 3, 4, then reverse to 0
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        request(3'd4);
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            if (bus.currentFloor == 3'd2 && bus.movingUp) found = 1'b1;
            else @(negedge clk);
        end
        check("sweep.reach2", int'(found), 1);
        request(3'd3);
        request(3'd0);
        prev_door = bus.doorOpen;
        for (int c = 0; c < 300 && stop_floor.size() < 3; c++) begin
            @(negedge clk);
            if (bus.doorOpen && !prev_door) begin
                stop_floor.push_back(int'(bus.currentFloor));
                stop_pend.push_back(int'(bus.pending));
            end
            prev_door = bus.doorOpen;
        end
        check("sweep.nstops", stop_floor.size(), 3);
        for (int s = 0; s < 3; s++) begin
            if (s < stop_floor.size()) begin
                check($sformatf("sweep.stop%0d.floor", s), stop_floor[s], exp_stop[s]);
                check($sformatf("sweep.stop%0d.pending", s), stop_pend[s], exp_spend[s]);
                $display("sweep stop %0d: floor=%0d pending=%05b", s, stop_floor[s], stop_pend[s][4:0]);
            end
        end

        // Test 5: reset asserted mid MOVE_UP
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        request(3'd3);
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            if (bus.currentFloor == 3'd1 && bus.movingUp) found = 1'b1;
            else @(negedge clk);
        end
        check("midrst.reach1", int'(found), 1);
        rst = 1'b1;
        @(negedge clk);
        check_all("midrst.rst", 0, 0, 0, 0, 5'b00000);
        rst = 1'b0;
        @(negedge clk);
        check_all("midrst.after", 0, 0, 0, 0, 5'b00000);
        $display("midrst: floor=%0d up=%0b pending=%b", bus.currentFloor, bus.movingUp, bus.pending);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
